// File: rtl/pwm_cmp_mux_sync.sv
// Double-buffered compare-word selector for the PWM path: a shadow select is
// committed to the active select on a programmable counter event, then the word is registered.
module pwm_cmp_mux_sync #(
  parameter  int N_IN    = 8,
  parameter  int WIDTH   = 16,
  parameter  int RST_SEL = 0,
  localparam int SELW    = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic                  en,
  input  logic [SELW-1:0]       sel_in,
  input  logic                  sel_wr,
  input  logic [1:0]            upd_mode,
  input  logic                  evt_zero,
  input  logic                  evt_prd,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic [SELW-1:0]       sel_active,
  output logic                  pend,
  output logic                  sel_err
);

  localparam logic [SELW:0]   NinW    = (SELW+1)'(N_IN);
  localparam logic [SELW-1:0] RstSelW = SELW'(RST_SEL);

  logic [SELW-1:0]  shadow_q, shadow_d;
  logic [SELW-1:0]  active_q, active_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;

  logic             wrOk;
  logic             ce;
  logic [WIDTH-1:0] word;

  // The extra leading zero keeps the range check exact when N_IN is a power of two.
  assign wrOk = sel_wr && ({1'b0, sel_in} < NinW);
  assign word = in_data[active_q*WIDTH +: WIDTH];

  always_comb begin
    ce = 1'b0;
    case (upd_mode)
      2'd0:    ce = 1'b1;
      2'd1:    ce = evt_zero;
      2'd2:    ce = evt_prd;
      default: ce = evt_zero | evt_prd;
    endcase
  end

  // A write coinciding with a commit event goes straight through to the active select.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    err_d    = sel_wr && !wrOk;
    out_d    = out_q;
    valid_d  = valid_q;
    if (wrOk) shadow_d = sel_in;
    if (ce && wrOk) begin
      active_d = sel_in;
      pend_d   = 1'b0;
    end else if (ce && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end else if (wrOk) begin
      pend_d = 1'b1;
    end
    if (en) begin
      out_d   = word;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= RstSelW;
      active_q <= RstSelW;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
    end
  end

  assign out_data   = out_q;
  assign out_valid  = valid_q;
  assign sel_active = active_q;
  assign pend       = pend_q;
  assign sel_err    = err_q;

endmodule

// File: tb/tb_pwm_cmp_mux_sync.sv
// Directed bench: an 8-input instance for the commit modes and reset,
// plus a 6-input instance for rejected writes and output hold.
module tb_pwm_cmp_mux_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-input instance
  logic [127:0] aData;
  logic         aEn, aSelWr, aEvtZero, aEvtPrd, aValid, aPend, aErr;
  logic [2:0]   aSelIn, aActive;
  logic [1:0]   aMode;
  logic [15:0]  aOut;

  // 6-input instance
  logic [95:0]  bData;
  logic         bEn, bSelWr, bValid, bPend, bErr;
  logic [2:0]   bSelIn, bActive;
  logic [15:0]  bOut;

  int total = 0;
  int bad   = 0;

  pwm_cmp_mux_sync #(.N_IN(8), .WIDTH(16), .RST_SEL(0)) dutA (
    .clk(clk), .rst(rst), .in_data(aData), .en(aEn), .sel_in(aSelIn),
    .sel_wr(aSelWr), .upd_mode(aMode), .evt_zero(aEvtZero), .evt_prd(aEvtPrd),
    .out_data(aOut), .out_valid(aValid), .sel_active(aActive), .pend(aPend),
    .sel_err(aErr)
  );

  pwm_cmp_mux_sync #(.N_IN(6), .WIDTH(16), .RST_SEL(0)) dutB (
    .clk(clk), .rst(rst), .in_data(bData), .en(bEn), .sel_in(bSelIn),
    .sel_wr(bSelWr), .upd_mode(2'd0), .evt_zero(1'b0), .evt_prd(1'b0),
    .out_data(bOut), .out_valid(bValid), .sel_active(bActive), .pend(bPend),
    .sel_err(bErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) aData[k*16 +: 16] = 16'h1000 + 16'(k);
    for (int k = 0; k < 6; k++) bData[k*16 +: 16] = 16'h2000 + 16'(k);
    aEn = 1'b1; aSelWr = 1'b0; aSelIn = '0; aMode = 2'd0; aEvtZero = 1'b0; aEvtPrd = 1'b0;
    bEn = 1'b1; bSelWr = 1'b0; bSelIn = '0;

    applyStimulus();
    checkOutput("rst_out",    32'(aOut),    32'h0);
    checkOutput("rst_valid",  32'(aValid),  32'h0);
    checkOutput("rst_active", 32'(aActive), 32'h0);
    checkOutput("rst_pend",   32'(aPend),   32'h0);
    applyStimulus();
    rst = 1'b0;
    checkOutput("rel_valid0", 32'(aValid), 32'h0);
    applyStimulus();
    checkOutput("rel_valid1", 32'(aValid),  32'h1);
    checkOutput("rel_out",    32'(aOut),    32'h1000);
    checkOutput("rel_active", 32'(aActive), 32'h0);

    // Mode 0: write-through, two-cycle latency to the output
    aSelIn = 3'd5; aSelWr = 1'b1;
    applyStimulus();
    aSelWr = 1'b0;
    checkOutput("m0_active", 32'(aActive), 32'h5);
    checkOutput("m0_pend",   32'(aPend),   32'h0);
    checkOutput("m0_out1",   32'(aOut),    32'h1000);
    applyStimulus();
    checkOutput("m0_out2", 32'(aOut),  32'h1005);
    checkOutput("m0_pend2", 32'(aPend), 32'h0);

    // Mode 1: commit only on evt_zero, evt_prd ignored
    aMode = 2'd1; aSelIn = 3'd3; aSelWr = 1'b1;
    applyStimulus();
    aSelWr = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      checkOutput("m1_pend",   32'(aPend),   32'h1);
      checkOutput("m1_active", 32'(aActive), 32'h5);
      aEvtPrd = (i == 4);
      applyStimulus();
    end
    aEvtPrd = 1'b0;
    checkOutput("m1_pend_t10", 32'(aPend), 32'h1);
    aEvtZero = 1'b1;
    applyStimulus();
    aEvtZero = 1'b0;
    checkOutput("m1_commit", 32'(aActive), 32'h3);
    checkOutput("m1_clear",  32'(aPend),   32'h0);
    checkOutput("m1_out_old", 32'(aOut),   32'h1005);
    applyStimulus();
    checkOutput("m1_out_new", 32'(aOut), 32'h1003);

    // Mode 2: last write wins, then write coinciding with evt_prd
    aMode = 2'd2; aSelIn = 3'd2; aSelWr = 1'b1;
    applyStimulus();
    checkOutput("m2_pend_a", 32'(aPend), 32'h1);
    aSelIn = 3'd6;
    applyStimulus();
    aSelWr = 1'b0;
    checkOutput("m2_pend_b",  32'(aPend),   32'h1);
    checkOutput("m2_hold",    32'(aActive), 32'h3);
    aEvtPrd = 1'b1;
    applyStimulus();
    checkOutput("m2_lastwin", 32'(aActive), 32'h6);
    checkOutput("m2_clear",   32'(aPend),   32'h0);
    aSelIn = 3'd4; aSelWr = 1'b1;
    applyStimulus();
    aSelWr = 1'b0; aEvtPrd = 1'b0;
    checkOutput("m2_thru",      32'(aActive), 32'h4);
    checkOutput("m2_thru_pend", 32'(aPend),   32'h0);
    applyStimulus();
    checkOutput("m2_out", 32'(aOut), 32'h1004);

    // Mode 3: both events together commit once; events with nothing pending do nothing
    aMode = 2'd3; aSelIn = 3'd1; aSelWr = 1'b1;
    applyStimulus();
    aSelWr = 1'b0;
    checkOutput("m3_pend", 32'(aPend), 32'h1);
    aEvtZero = 1'b1; aEvtPrd = 1'b1;
    applyStimulus();
    aEvtPrd = 1'b0;
    checkOutput("m3_commit", 32'(aActive), 32'h1);
    checkOutput("m3_clear",  32'(aPend),   32'h0);
    applyStimulus();
    aEvtZero = 1'b0;
    checkOutput("m3_idle_act",  32'(aActive), 32'h1);
    checkOutput("m3_idle_pend", 32'(aPend),   32'h0);

    // Switching to mode 0 with a pending select commits on the next cycle
    aMode = 2'd1; aSelIn = 3'd7; aSelWr = 1'b1;
    applyStimulus();
    aSelWr = 1'b0;
    checkOutput("sw_pend", 32'(aPend), 32'h1);
    aMode = 2'd0;
    applyStimulus();
    checkOutput("sw_commit", 32'(aActive), 32'h7);
    checkOutput("sw_clear",  32'(aPend),   32'h0);

    // Async reset mid-pend discards the pending select
    aMode = 2'd1; aSelIn = 3'd2; aSelWr = 1'b1;
    applyStimulus();
    aSelWr = 1'b0;
    checkOutput("ar_pend", 32'(aPend), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_out",    32'(aOut),    32'h0);
    checkOutput("ar_valid",  32'(aValid),  32'h0);
    checkOutput("ar_active", 32'(aActive), 32'h0);
    checkOutput("ar_pend0",  32'(aPend),   32'h0);
    applyStimulus();
    rst = 1'b0;
    aEvtZero = 1'b1;
    applyStimulus();
    aEvtZero = 1'b0;
    checkOutput("ar_evt_act",  32'(aActive), 32'h0);
    checkOutput("ar_evt_pend", 32'(aPend),   32'h0);

    // 6-input instance: rejected writes and output hold with en low
    bSelIn = 3'd3; bSelWr = 1'b1;
    applyStimulus();
    bSelWr = 1'b0;
    checkOutput("b_active3", 32'(bActive), 32'h3);
    checkOutput("b_noerr",   32'(bErr),    32'h0);
    applyStimulus();
    checkOutput("b_out3", 32'(bOut), 32'h2003);
    bSelIn = 3'd7; bSelWr = 1'b1;
    applyStimulus();
    bSelWr = 1'b0;
    checkOutput("b_err7",    32'(bErr),    32'h1);
    checkOutput("b_keep7",   32'(bActive), 32'h3);
    checkOutput("b_pend7",   32'(bPend),   32'h0);
    applyStimulus();
    checkOutput("b_err_one", 32'(bErr), 32'h0);
    bSelIn = 3'd6; bSelWr = 1'b1;
    applyStimulus();
    bSelWr = 1'b0;
    checkOutput("b_err6",  32'(bErr),    32'h1);
    checkOutput("b_keep6", 32'(bActive), 32'h3);
    bEn = 1'b0; bData[3*16 +: 16] = 16'hBEEF;
    applyStimulus();
    applyStimulus();
    checkOutput("b_frozen", 32'(bOut), 32'h2003);
    bEn = 1'b1;
    applyStimulus();
    checkOutput("b_follow", 32'(bOut), 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_cmp_mux_sync.md
Name: pwm_cmp_mux_sync

Overview:
- Parametrised successor to the fixed 8-input, 16-bit compare-value selector in the PWM path.
- Selects one of N_IN compare words and drives it to the PWM comparator through a registered output.
- The selection is double-buffered: software/sequencer writes a shadow select, and it is committed to the active select only at a programmable PWM counter event. This prevents a duty-cycle glitch in mid-period.
- Sits between the compare-value register bank and the PWM comparator.

Parameters:
- N_IN, 8: number of compare inputs, >= 2.
- WIDTH, 16: bits per compare word.
- RST_SEL, 0: reset value of the shadow and active select, < N_IN.
- SELW (localparam), $clog2(N_IN): select width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_data  in  N_IN*WIDTH  packed compare words; word k = in_data[k*WIDTH +: WIDTH]
- en  in  1  output register enable; 0 holds out_data
- sel_in  in  SELW  new select value
- sel_wr  in  1  write strobe for sel_in, single cycle
- upd_mode  in  2  commit mode: 0 immediate, 1 on evt_zero, 2 on evt_prd, 3 on evt_zero or evt_prd
- evt_zero  in  1  PWM counter-at-zero pulse
- evt_prd  in  1  PWM counter-at-period pulse
- out_data  out  WIDTH  registered selected compare word
- out_valid  out  1  out_data holds a selected word since reset
- sel_active  out  SELW  currently committed select
- pend  out  1  shadow written but not yet committed
- sel_err  out  1  one-cycle pulse on rejected write

Behaviour:
- Reset (async assert, synchronous release to clk): shadow = RST_SEL, sel_active = RST_SEL, out_data = 0, out_valid = 0, pend = 0, sel_err = 0. Reset in mid-operation discards any pending select.
- Write acceptance:
  - sel_wr = 1 with sel_in < N_IN: the write is accepted and shadow <= sel_in.
  - sel_wr = 1 with sel_in >= N_IN: the write is rejected, shadow is unchanged, and sel_err = 1 for exactly the next cycle. When N_IN is a power of two, this case cannot occur.
- Commit event ce, per cycle:
  - mode 0: ce = 1 every cycle.
  - mode 1: ce = evt_zero.
  - mode 2: ce = evt_prd.
  - mode 3: ce = evt_zero | evt_prd.
- Commit:
  - If ce = 1 and an accepted write occurs in the same cycle, sel_active <= sel_in (write-through). In mode 0 this gives sel_active = sel_in one cycle after sel_wr.
  - Else if ce = 1 and pend = 1, sel_active <= shadow and pend <= 0.
  - Else if an accepted write occurs, pend <= 1.
  - A further write while pend = 1 overwrites shadow; last write wins and pend stays 1.
- Mode change: upd_mode is sampled every cycle. A pending select commits at the first ce of the current mode. Switching to mode 0 with pend = 1 commits on the next cycle.
- Output:
  - When en = 1: out_data <= word[sel_active] and out_valid <= 1. In_data changes on the active word appear after 1 cycle.
  - When en = 0: out_data and out_valid hold.
  - Latency sel_wr -> out_data in mode 0 is 2 cycles: 1 to commit, 1 to register.
  - Event-driven commit: the new word appears on out_data 2 cycles after the event cycle, provided en = 1.
- Both evt_zero and evt_prd high in mode 3: a single commit, no double effect.
- Events while pend = 0 and no write: no state change.

Test Plan:
- Reset release, N_IN=8, WIDTH=16, in words k = 16'h1000+k, en = 1 -> out_valid = 0 in cycle 0 after release; then out_valid = 1, out_data = 16'h1000, sel_active = 0, pend = 0.
- Mode 0: sel_wr with sel_in = 5 at cycle t -> sel_active = 5 at t+1, out_data = 16'h1005 at t+2, pend never 1.
- Mode 1: write 3 at t, evt_zero at t+10 -> pend = 1 during t+1..t+10, sel_active = 3 at t+11, out_data = 16'h1003 at t+12; evt_prd pulses in between have no effect.
- Mode 2: write 2, then write 6 before evt_prd, then evt_prd -> sel_active = 6 (last write wins). Write 4 in the same cycle as evt_prd -> sel_active = 4 next cycle.
- N_IN=6: write sel_in = 7 -> sel_err pulses 1 cycle, shadow/pend/sel_active unchanged. en = 0 with in_data changing -> out_data frozen.
- Write 7 in mode 1 (pend = 1), assert rst before evt_zero -> all outputs at reset values immediately (async); after release, evt_zero leaves sel_active = RST_SEL.
